dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, data-memory byte-address width.
REQ-002 Parameter STARVE_LIMIT, default 8, consecutive denied port-1 cycles before port 1 is forced ahead of port 0.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 p0_req_i / p0_we_i  input  1 each  pipeline memory-stage request and write flag (we=0 means read).
REQ-006 p0_addr_i  input  ADDR_WIDTH  pipeline byte address.
REQ-007 p0_wdata_i  input  32  pipeline write data.
REQ-008 p0_gnt_o / p0_rvalid_o  output  1 each  pipeline grant and read-data valid.
REQ-009 p0_rdata_o  output  32  pipeline read data.
REQ-010 stall_o  output  1  high when p0_req_i=1 and p0_gnt_o=0.
REQ-011 p1_req_i / p1_we_i  input  1 each  DMA/debug request and write flag.
REQ-012 p1_addr_i  input  ADDR_WIDTH  DMA burst start address.
REQ-013 p1_len_i  input  4  burst length minus one (0..15 gives 1..16 beats).
REQ-014 p1_wdata_i  input  32  DMA write data, sampled each granted beat.
REQ-015 p1_gnt_o / p1_rvalid_o  output  1 each  DMA per-beat grant and read-data valid.
REQ-016 p1_rdata_o  output  32  DMA read data.
REQ-017 busy_o  output  1  high while a port-1 burst is in progress.
REQ-018 mem_addr_o  output  ADDR_WIDTH  memory word address; bits [1:0] always 0.
REQ-019 mem_re_o / mem_we_o  output  1 each  memory read and write strobes; never both high.
REQ-020 mem_wdata_o  output  32  memory write data.
REQ-021 mem_rdata_i  input  32  memory read data, valid one cycle after mem_re_o.

Function
REQ-022 FSM states SHALL be IDLE and BURST; reset state IDLE.
REQ-023 In IDLE, a request SHALL be granted in the same cycle (combinational gnt) and the access issued on mem_* that cycle.
REQ-024 In IDLE with both requests high, port 0 SHALL win unless the starve counter equals STARVE_LIMIT, in which case port 1 wins.
REQ-025 The starve counter SHALL increment, saturating at STARVE_LIMIT, each cycle p1_req_i=1 without p1_gnt_o, and clear on any p1 grant or when p1_req_i=0.
REQ-026 A port-0 grant SHALL be exactly one access; FSM stays IDLE.
REQ-027 A port-1 grant with p1_len_i=L SHALL latch the start address, we and L, issue beat 0 that cycle, and enter BURST if L>0.
REQ-028 In BURST, one beat SHALL issue per cycle with p1_gnt_o=1, address = start + 4*beat modulo 2^ADDR_WIDTH; FSM returns to IDLE after beat L.
REQ-029 Port 0 SHALL be denied throughout BURST; stall_o follows REQ-010.
REQ-030 In BURST, p1_req_i, p1_addr_i, p1_len_i and p1_we_i changes SHALL be ignored; the burst is not abortable.
REQ-031 rvalid for a port SHALL pulse one cycle after each read beat it was granted, with rdata = mem_rdata_i; writes produce no rvalid.
REQ-032 Requesters SHALL hold req, we, addr and wdata stable until granted; the arbiter SHALL not register ungranted requests.
REQ-033 When no grant is given, mem_re_o=mem_we_o=0 and mem_addr_o/mem_wdata_o hold their last issued values.

Reset
REQ-034 On rst=1 at a clock edge: FSM to IDLE, burst counters and starve counter to 0, all rvalid to 0, rdata to 0, mem_addr_o and mem_wdata_o to 0.
REQ-035 Reset asserted mid-burst SHALL drop remaining beats; pending rvalid pulses SHALL be suppressed.
REQ-036 While rst=1, all gnt, strobes, stall_o and busy_o SHALL be 0.

Verification
REQ-037 p0 read at 0x104, mem_rdata_i=0xDEADBEEF -> p0_gnt_o and mem_re_o same cycle, mem_addr_o=0x104, p0_rvalid_o next cycle with 0xDEADBEEF.
REQ-038 p1 write, addr 0x3F8, len 3, ADDR_WIDTH 10 -> 4 consecutive beats at 0x3F8, 0x3FC, 0x000, 0x004; busy_o high 3 cycles after beat 0.
REQ-039 p0 request during a p1 4-beat burst -> stall_o high until the burst ends, p0 granted the cycle after the last beat.
REQ-040 p0 and p1 requesting continuously -> p0 granted 8 cycles, p1 granted on the 9th, starve counter cleared.
REQ-041 rst during beat 2 of a 16-beat read -> no further beats, no rvalid pulse after reset, FSM IDLE.
REQ-042 Address 0x107 on p0 -> mem_addr_o=0x104; assert mem_re_o and mem_we_o never both high throughout.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dmem_arbiter_if                                         |
// | Description : Bundle of the pipeline port (p0), the DMA/debug burst   |
// |               port (p1) and the data-memory side of dmem_arbiter.     |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
interface dmem_arbiter_if #(
  parameter int ADDR_WIDTH = 10
);
  // Pipeline port
  logic                  p0_req_i;
  logic                  p0_we_i;
  logic [ADDR_WIDTH-1:0] p0_addr_i;
  logic [31:0]           p0_wdata_i;
  logic                  p0_gnt_o;
  logic                  p0_rvalid_o;
  logic [31:0]           p0_rdata_o;
  logic                  stall_o;
  // DMA / debug burst port
  logic                  p1_req_i;
  logic                  p1_we_i;
  logic [ADDR_WIDTH-1:0] p1_addr_i;
  logic [3:0]            p1_len_i;
  logic [31:0]           p1_wdata_i;
  logic                  p1_gnt_o;
  logic                  p1_rvalid_o;
  logic [31:0]           p1_rdata_o;
  logic                  busy_o;
  // Memory side
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_re_o;
  logic                  mem_we_o;
  logic [31:0]           mem_wdata_o;
  logic [31:0]           mem_rdata_i;

  // Arbiter side
  modport slave (
    input  p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
    output p0_gnt_o, p0_rvalid_o, p0_rdata_o, stall_o,
    input  p1_req_i, p1_we_i, p1_addr_i, p1_len_i, p1_wdata_i,
    output p1_gnt_o, p1_rvalid_o, p1_rdata_o, busy_o,
    output mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o,
    input  mem_rdata_i
  );

  // Requester / memory-model side
  modport master (
    output p0_req_i, p0_we_i, p0_addr_i, p0_wdata_i,
    input  p0_gnt_o, p0_rvalid_o, p0_rdata_o, stall_o,
    output p1_req_i, p1_we_i, p1_addr_i, p1_len_i, p1_wdata_i,
    input  p1_gnt_o, p1_rvalid_o, p1_rdata_o, busy_o,
    input  mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o,
    output mem_rdata_i
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dmem_arbiter                                            |
// | Description : Two-port data-memory arbiter. Port 0 (pipeline) has     |
// |               priority for single accesses; port 1 (DMA/debug) issues |
// |               non-abortable word bursts and is forced ahead of port 0 |
// |               after STARVE_LIMIT consecutive denied cycles.           |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = 8
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam int c_WORD_W   = ADDR_WIDTH - 2;
  localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t                  r_state;
  logic [c_WORD_W-1:0]     r_base_word;
  logic                    r_we;
  logic [3:0]              r_len;
  logic [3:0]              r_beat;
  logic [c_STARVE_W-1:0]   r_starve;
  logic [ADDR_WIDTH-1:0]   r_addr_last;
  logic [31:0]             r_wdata_last;
  logic                    r_p0_rvalid;
  logic                    r_p1_rvalid;
  logic [31:0]             r_p0_rdata;
  logic [31:0]             r_p1_rdata;

  logic                    w_p0_gnt;
  logic                    w_p1_gnt;
  logic                    w_grant;
  logic                    w_issue_we;
  logic [ADDR_WIDTH-1:0]   w_issue_addr;
  logic [31:0]             w_issue_wdata;
  logic                    w_starved;
  logic                    w_unused;

  // Byte-lane bits of the request addresses are dropped: memory is word addressed.
  assign w_unused  = &{1'b0, bus.p0_addr_i[1:0], bus.p1_addr_i[1:0]};
  assign w_starved = (r_starve == c_STARVE_MAX);

  // Grant selection and the access issued this cycle; no grant leaves the last address on the bus.
  always_comb begin
    w_p0_gnt      = 1'b0;
    w_p1_gnt      = 1'b0;
    w_issue_we    = 1'b0;
    w_issue_addr  = r_addr_last;
    w_issue_wdata = bus.p1_wdata_i;
    if (!rst) begin
      if (r_state == S_BURST) begin
        // Burst beats walk word by word and wrap at the top of the address space.
        w_p1_gnt     = 1'b1;
        w_issue_we   = r_we;
        w_issue_addr = {r_base_word + c_WORD_W'(r_beat), 2'b00};
      end else if (bus.p1_req_i && (!bus.p0_req_i || w_starved)) begin
        w_p1_gnt     = 1'b1;
        w_issue_we   = bus.p1_we_i;
        w_issue_addr = {bus.p1_addr_i[ADDR_WIDTH-1:2], 2'b00};
      end else if (bus.p0_req_i) begin
        w_p0_gnt      = 1'b1;
        w_issue_we    = bus.p0_we_i;
        w_issue_addr  = {bus.p0_addr_i[ADDR_WIDTH-1:2], 2'b00};
        w_issue_wdata = bus.p0_wdata_i;
      end
    end
  end

  assign w_grant = w_p0_gnt | w_p1_gnt;

  assign bus.p0_gnt_o    = w_p0_gnt;
  assign bus.p1_gnt_o    = w_p1_gnt;
  assign bus.stall_o     = !rst && bus.p0_req_i && !w_p0_gnt;
  assign bus.busy_o      = !rst && (r_state == S_BURST);
  assign bus.mem_addr_o  = w_issue_addr;
  assign bus.mem_re_o    = w_grant && !w_issue_we;
  assign bus.mem_we_o    = w_grant && w_issue_we;
  assign bus.mem_wdata_o = (w_grant && w_issue_we) ? w_issue_wdata : r_wdata_last;
  // Read data arrives from memory in the rvalid cycle; it is passed through then and held afterwards.
  assign bus.p0_rvalid_o = r_p0_rvalid;
  assign bus.p1_rvalid_o = r_p1_rvalid;
  assign bus.p0_rdata_o  = r_p0_rvalid ? bus.mem_rdata_i : r_p0_rdata;
  assign bus.p1_rdata_o  = r_p1_rvalid ? bus.mem_rdata_i : r_p1_rdata;

  // FSM, burst bookkeeping, starvation counter and registered read-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_base_word  <= '0;
      r_we         <= 1'b0;
      r_len        <= 4'd0;
      r_beat       <= 4'd0;
      r_starve     <= '0;
      r_addr_last  <= '0;
      r_wdata_last <= 32'd0;
      r_p0_rvalid  <= 1'b0;
      r_p1_rvalid  <= 1'b0;
      r_p0_rdata   <= 32'd0;
      r_p1_rdata   <= 32'd0;
    end else begin
      r_p0_rvalid <= w_p0_gnt && !w_issue_we;
      r_p1_rvalid <= w_p1_gnt && !w_issue_we;
      if (r_p0_rvalid) r_p0_rdata <= bus.mem_rdata_i;
      if (r_p1_rvalid) r_p1_rdata <= bus.mem_rdata_i;
      if (w_grant) r_addr_last <= w_issue_addr;
      if (w_grant && w_issue_we) r_wdata_last <= w_issue_wdata;

      if (bus.p1_req_i && !w_p1_gnt) begin
        if (!w_starved) r_starve <= r_starve + c_STARVE_W'(1);
      end else begin
        r_starve <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_p1_gnt) begin
            r_base_word <= bus.p1_addr_i[ADDR_WIDTH-1:2];
            r_we        <= bus.p1_we_i;
            r_len       <= bus.p1_len_i;
            r_beat      <= 4'd1;
            if (bus.p1_len_i != 4'd0) r_state <= S_BURST;
          end
        end
        S_BURST: begin
          if (r_beat == r_len) begin
            r_state <= S_IDLE;
            r_beat  <= 4'd0;
          end else begin
            r_beat <= r_beat + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_dmem_arbiter                                         |
// | Description : Self-checking bench for dmem_arbiter: directed scenarios|
// |               with literal expectations plus randomized traffic       |
// |               checked against a queue-based behavioural model.        |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module tb_dmem_arbiter;

  localparam int AW  = 10;
  localparam int LIM = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  dmem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Model state: outstanding burst beats as a list of addresses.
  logic [AW-1:0] m_bq[$];
  bit            m_bwe;
  int            m_starve;
  logic [AW-1:0] m_last_addr;
  logic [31:0]   m_last_wdata;
  bit            m_rv0, m_rv1;
  bit            e_p0g, e_p1g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] align(input logic [AW-1:0] a);
    return {a[AW-1:2], 2'b00};
  endfunction

  task automatic model_reset();
    m_bq.delete();
    m_bwe        = 1'b0;
    m_starve     = 0;
    m_last_addr  = '0;
    m_last_wdata = 32'd0;
    m_rv0        = 1'b0;
    m_rv1        = 1'b0;
  endtask

  // Mid-cycle: predict outputs from the model, compare, then advance the model past the edge.
  task automatic settle_check();
    logic [AW-1:0] e_addr;
    logic [31:0]   e_wd;
    logic [AW-1:0] base;
    bit g0, g1, e_we, e_re, in_burst;
    #4;
    in_burst = (m_bq.size() != 0);
    g0 = 1'b0; g1 = 1'b0; e_we = 1'b0;
    e_addr = m_last_addr;
    e_wd   = m_last_wdata;
    if (!rst) begin
      if (in_burst) begin
        g1 = 1'b1; e_addr = m_bq[0]; e_we = m_bwe; e_wd = bus.p1_wdata_i;
      end else if (bus.p1_req_i && (!bus.p0_req_i || m_starve == LIM)) begin
        g1 = 1'b1; e_addr = align(bus.p1_addr_i); e_we = bus.p1_we_i; e_wd = bus.p1_wdata_i;
      end else if (bus.p0_req_i) begin
        g0 = 1'b1; e_addr = align(bus.p0_addr_i); e_we = bus.p0_we_i; e_wd = bus.p0_wdata_i;
      end
    end
    e_re = (g0 || g1) && !e_we;
    chk("p0_gnt", 32'(bus.p0_gnt_o), 32'(g0));
    chk("p1_gnt", 32'(bus.p1_gnt_o), 32'(g1));
    chk("stall", 32'(bus.stall_o), 32'(!rst && bus.p0_req_i && !g0));
    chk("busy", 32'(bus.busy_o), 32'(!rst && in_burst));
    chk("mem_re", 32'(bus.mem_re_o), 32'(e_re));
    chk("mem_we", 32'(bus.mem_we_o), 32'((g0 || g1) && e_we));
    chk("strobe_excl", 32'(bus.mem_re_o && bus.mem_we_o), 32'(0));
    chk("mem_addr", 32'(bus.mem_addr_o), 32'(e_addr));
    if ((g0 || g1) && e_we) chk("mem_wdata", bus.mem_wdata_o, e_wd);
    chk("p0_rvalid", 32'(bus.p0_rvalid_o), 32'(m_rv0));
    chk("p1_rvalid", 32'(bus.p1_rvalid_o), 32'(m_rv1));
    if (m_rv0) chk("p0_rdata", bus.p0_rdata_o, bus.mem_rdata_i);
    if (m_rv1) chk("p1_rdata", bus.p1_rdata_o, bus.mem_rdata_i);

    if (rst) begin
      model_reset();
    end else begin
      m_rv0 = g0 && !e_we;
      m_rv1 = g1 && !e_we;
      if (g0 || g1) m_last_addr = e_addr;
      if ((g0 || g1) && e_we) m_last_wdata = e_wd;
      if (bus.p1_req_i && !g1) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
      else m_starve = 0;
      if (in_burst) begin
        void'(m_bq.pop_front());
      end else if (g1) begin
        m_bwe = bus.p1_we_i;
        base  = align(bus.p1_addr_i);
        for (int k = 1; k <= int'(bus.p1_len_i); k++) m_bq.push_back(base + AW'(4 * k));
      end
    end
    e_p0g = g0;
    e_p1g = g1;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    bus.mem_rdata_i = $urandom;
  endtask

  task automatic idle_inputs();
    bus.p0_req_i = 1'b0; bus.p0_we_i = 1'b0; bus.p0_addr_i = '0; bus.p0_wdata_i = 32'd0;
    bus.p1_req_i = 1'b0; bus.p1_we_i = 1'b0; bus.p1_addr_i = '0; bus.p1_len_i = 4'd0;
    bus.p1_wdata_i = 32'd0;
  endtask

  logic [AW-1:0] exp38 [4];
  int  np0;
  bit  p0_pend, p1_pend, was_burst;

  initial begin
    exp38[0] = 10'h3F8; exp38[1] = 10'h3FC; exp38[2] = 10'h000; exp38[3] = 10'h004;
    idle_inputs();
    bus.mem_rdata_i = 32'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;

    // Post-reset state
    settle_check();
    chk("rst_p0_rdata", bus.p0_rdata_o, 32'd0);
    chk("rst_p1_rdata", bus.p1_rdata_o, 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr_o), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
    nxt();

    // Single p0 read with data returned next cycle
    bus.p0_req_i = 1'b1; bus.p0_we_i = 1'b0; bus.p0_addr_i = 10'h104;
    settle_check();
    chk("r37_gnt", 32'(bus.p0_gnt_o), 32'd1);
    chk("r37_re", 32'(bus.mem_re_o), 32'd1);
    chk("r37_addr", 32'(bus.mem_addr_o), 32'h104);
    nxt();
    bus.p0_req_i = 1'b0; bus.mem_rdata_i = 32'hDEADBEEF;
    settle_check();
    chk("r37_rvalid", 32'(bus.p0_rvalid_o), 32'd1);
    chk("r37_rdata", bus.p0_rdata_o, 32'hDEADBEEF);
    nxt();

    // Unaligned p0 write is word aligned
    bus.p0_req_i = 1'b1; bus.p0_we_i = 1'b1; bus.p0_addr_i = 10'h107; bus.p0_wdata_i = 32'h12345678;
    settle_check();
    chk("r42_addr", 32'(bus.mem_addr_o), 32'h104);
    chk("r42_we", 32'(bus.mem_we_o), 32'd1);
    nxt();
    idle_inputs();

    // 4-beat p1 write burst wrapping the address space; p1 inputs scrambled mid-burst
    bus.p1_req_i = 1'b1; bus.p1_we_i = 1'b1; bus.p1_addr_i = 10'h3F8; bus.p1_len_i = 4'd3;
    for (int b = 0; b < 4; b++) begin
      bus.p1_wdata_i = 32'hA0 + 32'(b);
      if (b > 0) begin
        bus.p1_req_i = 1'($urandom); bus.p1_we_i = 1'($urandom);
        bus.p1_addr_i = AW'($urandom); bus.p1_len_i = 4'($urandom);
      end
      settle_check();
      chk("r38_addr", 32'(bus.mem_addr_o), 32'(exp38[b]));
      chk("r38_gnt", 32'(bus.p1_gnt_o), 32'd1);
      chk("r38_busy", 32'(bus.busy_o), 32'(b > 0));
      chk("r38_wdata", bus.mem_wdata_o, 32'hA0 + 32'(b));
      nxt();
    end
    idle_inputs();
    settle_check();
    chk("r38_busy_end", 32'(bus.busy_o), 32'd0);
    nxt();

    // p0 stalls behind a 4-beat p1 read burst
    bus.p1_req_i = 1'b1; bus.p1_we_i = 1'b0; bus.p1_addr_i = 10'h040; bus.p1_len_i = 4'd3;
    settle_check();
    nxt();
    bus.p1_req_i = 1'b0;
    bus.p0_req_i = 1'b1; bus.p0_we_i = 1'b0; bus.p0_addr_i = 10'h200;
    for (int b = 1; b < 4; b++) begin
      settle_check();
      chk("r39_stall", 32'(bus.stall_o), 32'd1);
      nxt();
    end
    settle_check();
    chk("r39_p0_gnt", 32'(bus.p0_gnt_o), 32'd1);
    chk("r39_stall_end", 32'(bus.stall_o), 32'd0);
    nxt();
    idle_inputs();
    settle_check();
    nxt();

    // Continuous contention: p1 wins on the 9th cycle, then p0 again
    bus.p0_req_i = 1'b1; bus.p0_addr_i = 10'h010;
    bus.p1_req_i = 1'b1; bus.p1_addr_i = 10'h020; bus.p1_len_i = 4'd0;
    np0 = 0;
    for (int c = 1; c <= 9; c++) begin
      settle_check();
      if (c <= 8) np0 += int'(bus.p0_gnt_o);
      if (c == 9) chk("r40_p1_9th", 32'(bus.p1_gnt_o), 32'd1);
      nxt();
    end
    chk("r40_p0_count", 32'(np0), 32'd8);
    settle_check();
    chk("r40_p0_after", 32'(bus.p0_gnt_o), 32'd1);
    nxt();
    idle_inputs();

    // Reset during beat 2 of a 16-beat read
    bus.p1_req_i = 1'b1; bus.p1_we_i = 1'b0; bus.p1_addr_i = 10'h100; bus.p1_len_i = 4'd15;
    settle_check();
    nxt();
    bus.p1_req_i = 1'b0;
    settle_check();
    nxt();
    rst = 1'b1;
    settle_check();
    chk("r41_gnt_in_rst", 32'(bus.p1_gnt_o), 32'd0);
    nxt();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      settle_check();
      chk("r41_gnt", 32'(bus.p1_gnt_o), 32'd0);
      chk("r41_rvalid", 32'(bus.p1_rvalid_o), 32'd0);
      chk("r41_busy", 32'(bus.busy_o), 32'd0);
      nxt();
    end

    // Randomized traffic against the model
    p0_pend = 1'b0; p1_pend = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!p0_pend) begin
        bus.p0_req_i   = ($urandom_range(0, 99) < 75);
        bus.p0_we_i    = 1'($urandom);
        bus.p0_addr_i  = AW'($urandom);
        bus.p0_wdata_i = $urandom;
        p0_pend = bus.p0_req_i;
      end
      was_burst = (m_bq.size() != 0);
      if (was_burst) begin
        bus.p1_req_i  = 1'($urandom); bus.p1_we_i = 1'($urandom);
        bus.p1_addr_i = AW'($urandom); bus.p1_len_i = 4'($urandom);
        bus.p1_wdata_i = $urandom;
        p1_pend = 1'b0;
      end else if (!p1_pend) begin
        bus.p1_req_i   = ($urandom_range(0, 99) < 40);
        bus.p1_we_i    = 1'($urandom);
        bus.p1_addr_i  = AW'($urandom);
        bus.p1_len_i   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15))
                                                     : 4'($urandom_range(0, 2));
        bus.p1_wdata_i = $urandom;
        p1_pend = bus.p1_req_i;
      end
      settle_check();
      if (e_p0g) p0_pend = 1'b0;
      if (e_p1g && !was_burst) p1_pend = 1'b0;
      nxt();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
